// File: rtl/frontend_sweep_controller_pkg.sv
// Shared definitions for the frontend frequency-sweep sequencer.
package frontend_sweep_controller_pkg;

  // Sweep sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_OUTPUT  = 3'd4,
    ST_STEP    = 3'd5,
    ST_FINISH  = 3'd6
  } sweep_state_e;

  // |sin|+|cos| needs one bit more than a single mul-acc value so that
  // 2^(W-1) + 2^(W-1) is representable without saturation.
  function automatic int mag_width(input int acc_width);
    return acc_width + 1;
  endfunction

endpackage

// File: rtl/sweep_peak_tracker.sv
// Tracks the sweep step with the largest |sin|+|cos| magnitude.
module sweep_peak_tracker
  import frontend_sweep_controller_pkg::*;
#(
  parameter int MUL_ACC_WIDTH        = 32,
  parameter int STEP_COUNT_BITS      = 10,
  parameter int PHASE_INCREMENT_BITS = 28
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clear,
  input  logic                              capture,
  input  logic signed [MUL_ACC_WIDTH-1:0]   sin_val,
  input  logic signed [MUL_ACC_WIDTH-1:0]   cos_val,
  input  logic [STEP_COUNT_BITS-1:0]        index,
  input  logic [PHASE_INCREMENT_BITS-1:0]   phase_inc,
  output logic [STEP_COUNT_BITS-1:0]        peak_index,
  output logic [PHASE_INCREMENT_BITS-1:0]   peak_phase_inc
);

  localparam int MAG_W = mag_width(MUL_ACC_WIDTH);

  logic [MAG_W-1:0] mag;
  logic [MAG_W-1:0] peak_mag;
  logic             peak_valid;

  // Two's-complement absolute value as unsigned; the most-negative value
  // maps to 2^(W-1), which fits exactly in W unsigned bits.
  function automatic logic [MUL_ACC_WIDTH-1:0] abs_val(input logic signed [MUL_ACC_WIDTH-1:0] x);
    logic [MUL_ACC_WIDTH-1:0] u;
    u = x;
    return x[MUL_ACC_WIDTH-1] ? (~u + MUL_ACC_WIDTH'(1)) : u;
  endfunction

  assign mag = {1'b0, abs_val(sin_val)} + {1'b0, abs_val(cos_val)};

  // Peak registers: cleared at sweep start, updated on strictly larger magnitude.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst_n) begin
      peak_mag       <= '0;
      peak_valid     <= 1'b0;
      peak_index     <= '0;
      peak_phase_inc <= '0;
    end else if (clear) begin
      peak_mag   <= '0;
      peak_valid <= 1'b0;
    end else if (capture && (!peak_valid || mag > peak_mag)) begin
      peak_mag       <= mag;
      peak_valid     <= 1'b1;
      peak_index     <= index;
      peak_phase_inc <= phase_inc;
    end
  end

endmodule

// File: rtl/frontend_sweep_controller.sv
// Steps the frontend phase increment through a programmed sweep, captures the
// settled SIN/COS mul-acc pair at each step, streams it out and tracks the peak.
module frontend_sweep_controller
  import frontend_sweep_controller_pkg::*;
#(
  parameter int PHASE_INCREMENT_BITS = 28,
  parameter int MUL_ACC_WIDTH        = 32,
  parameter int STEP_COUNT_BITS      = 10,
  parameter int SETTLE_BITS          = 16
) (
  input  logic                              CLK,
  input  logic                              RESET_N,
  input  logic                              CE,
  input  logic                              START,
  input  logic                              ABORT,
  input  logic [PHASE_INCREMENT_BITS-1:0]   START_PHASE_INC,
  input  logic [PHASE_INCREMENT_BITS-1:0]   STEP_PHASE_INC,
  input  logic [STEP_COUNT_BITS-1:0]        STEP_COUNT,
  input  logic [SETTLE_BITS-1:0]            SETTLE_CYCLES,
  input  logic signed [MUL_ACC_WIDTH-1:0]   SIN_MUL_ACC,
  input  logic signed [MUL_ACC_WIDTH-1:0]   COS_MUL_ACC,
  output logic [PHASE_INCREMENT_BITS-1:0]   PHASE_INCREMENT_OUT,
  output logic                              BUSY,
  output logic                              RES_VALID,
  input  logic                              RES_READY,
  output logic [STEP_COUNT_BITS-1:0]        RES_INDEX,
  output logic signed [MUL_ACC_WIDTH-1:0]   RES_SIN,
  output logic signed [MUL_ACC_WIDTH-1:0]   RES_COS,
  output logic [STEP_COUNT_BITS-1:0]        PEAK_INDEX,
  output logic [PHASE_INCREMENT_BITS-1:0]   PEAK_PHASE_INC,
  output logic                              DONE
);

  logic [1:0]                        rst_sync;
  logic                              rst_n;
  sweep_state_e                      state, state_next;

  logic [PHASE_INCREMENT_BITS-1:0]   cfg_start_inc;
  logic [PHASE_INCREMENT_BITS-1:0]   cfg_step_inc;
  logic [STEP_COUNT_BITS-1:0]        cfg_last_index;
  logic [SETTLE_BITS-1:0]            cfg_settle;

  logic [PHASE_INCREMENT_BITS-1:0]   phase_q;
  logic [STEP_COUNT_BITS-1:0]        index_q;
  logic [SETTLE_BITS-1:0]            settle_cnt;

  // Per-cycle actions decoded by the FSM; all already qualified by CE and ABORT.
  logic sample_cfg, do_load, do_dec, do_capture, do_step, clr_valid;

  // Reset synchronizer: asserts asynchronously, releases on the clock.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  // FSM state register.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // FSM next-state and action decode; nothing advances on CE=0, ABORT wins.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_next = state;
    sample_cfg = 1'b0;
    do_load    = 1'b0;
    do_dec     = 1'b0;
    do_capture = 1'b0;
    do_step    = 1'b0;
    clr_valid  = 1'b0;
    if (CE) begin
      if (ABORT) begin
        state_next = ST_IDLE;
        clr_valid  = 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (START) begin
              sample_cfg = 1'b1;
              state_next = ST_LOAD;
            end
          end
          ST_LOAD: begin
            do_load    = 1'b1;
            state_next = ST_SETTLE;
          end
          ST_SETTLE: begin
            if (settle_cnt == '0) state_next = ST_CAPTURE;
            else                  do_dec     = 1'b1;
          end
          ST_CAPTURE: begin
            do_capture = 1'b1;
            state_next = ST_OUTPUT;
          end
          ST_OUTPUT: begin
            if (RES_VALID && RES_READY) begin
              clr_valid  = 1'b1;
              state_next = (index_q == cfg_last_index) ? ST_FINISH : ST_STEP;
            end
          end
          ST_STEP: begin
            do_step    = 1'b1;
            state_next = ST_SETTLE;
          end
          ST_FINISH: state_next = ST_IDLE;
          default:   state_next = ST_IDLE;
        endcase
      end
    end
  end

  // Sweep configuration, frozen at START so mid-sweep input changes are ignored.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cfg_start_inc  <= '0;
      cfg_step_inc   <= '0;
      cfg_last_index <= '0;
      cfg_settle     <= '0;
    end else if (sample_cfg) begin
      cfg_start_inc  <= START_PHASE_INC;
      cfg_step_inc   <= STEP_PHASE_INC;
      // A step count of 0 behaves as a single-step sweep.
      cfg_last_index <= (STEP_COUNT == '0) ? '0 : STEP_COUNT - STEP_COUNT_BITS'(1);
      cfg_settle     <= SETTLE_CYCLES;
    end
  end

  // Tuning word, step index and settle counter.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= '0;
      index_q    <= '0;
      settle_cnt <= '0;
    end else if (do_load) begin
      phase_q    <= cfg_start_inc;
      index_q    <= '0;
      settle_cnt <= cfg_settle;
    end else if (do_step) begin
      phase_q    <= phase_q + cfg_step_inc;
      index_q    <= index_q + STEP_COUNT_BITS'(1);
      settle_cnt <= cfg_settle;
    end else if (do_dec) begin
      settle_cnt <= settle_cnt - SETTLE_BITS'(1);
    end
  end

  // Result register: loaded at capture, held until accepted or aborted.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      RES_VALID <= 1'b0;
      RES_INDEX <= '0;
      RES_SIN   <= '0;
      RES_COS   <= '0;
    end else if (do_capture) begin
      RES_VALID <= 1'b1;
      RES_INDEX <= index_q;
      RES_SIN   <= SIN_MUL_ACC;
      RES_COS   <= COS_MUL_ACC;
    end else if (clr_valid) begin
      RES_VALID <= 1'b0;
    end
  end

  sweep_peak_tracker #(
    .MUL_ACC_WIDTH        (MUL_ACC_WIDTH),
    .STEP_COUNT_BITS      (STEP_COUNT_BITS),
    .PHASE_INCREMENT_BITS (PHASE_INCREMENT_BITS)
  ) u_peak (
    .clk            (CLK),
    .rst_n          (rst_n),
    .clear          (do_load),
    .capture        (do_capture),
    .sin_val        (SIN_MUL_ACC),
    .cos_val        (COS_MUL_ACC),
    .index          (index_q),
    .phase_inc      (phase_q),
    .peak_index     (PEAK_INDEX),
    .peak_phase_inc (PEAK_PHASE_INC)
  );

  assign PHASE_INCREMENT_OUT = phase_q;
  assign BUSY                = (state != ST_IDLE);
  assign DONE                = (state == ST_FINISH);

endmodule

// File: doc/frontend_sweep_controller.md
Name: frontend_sweep_controller

Overview:
Sequencer that drives PHASE_INCREMENT_IN of the ADC/DAC frontend through a programmed frequency sweep. At each step it waits for the phase-increment and result IIR filters to settle, then captures the filtered SIN/COS mul-acc pair. Each capture is streamed out over a valid/ready handshake, and the step with the largest |SIN|+|COS| magnitude is tracked. It sits between the control/CPU register interface and the frontend, and is used for resonance search at power-up and on retune.

Parameters:
PHASE_INCREMENT_BITS, 28, width of the phase increment driven to the frontend
MUL_ACC_WIDTH, 32, width of the signed SIN/COS mul-acc inputs
STEP_COUNT_BITS, 10, width of the step count and step index
SETTLE_BITS, 16, width of the settle-cycle counter

Ports:
CLK  in  1  clock
RESET_N  in  1  asynchronous reset, active-low
CE  in  1  clock enable, shared with the frontend; all state holds when 0
START  in  1  pulse; begins a sweep when in IDLE, ignored otherwise
ABORT  in  1  level; returns to IDLE at the next CE cycle
START_PHASE_INC  in  PHASE_INCREMENT_BITS  first-step increment, sampled at START
STEP_PHASE_INC  in  PHASE_INCREMENT_BITS  per-step increment added, sampled at START
STEP_COUNT  in  STEP_COUNT_BITS  number of steps N, sampled at START; 0 is treated as 1
SETTLE_CYCLES  in  SETTLE_BITS  CE cycles to wait after each frequency change, sampled at START
SIN_MUL_ACC  in  MUL_ACC_WIDTH  signed, filtered, from the frontend
COS_MUL_ACC  in  MUL_ACC_WIDTH  signed, filtered, from the frontend
PHASE_INCREMENT_OUT  out  PHASE_INCREMENT_BITS  to the frontend PHASE_INCREMENT_IN
BUSY  out  1  high in every state except IDLE
RES_VALID  out  1  a captured result is presented
RES_READY  in  1  consumer accepts the result
RES_INDEX  out  STEP_COUNT_BITS  step index of the result, counting from 0
RES_SIN, RES_COS  out  MUL_ACC_WIDTH  captured values
PEAK_INDEX  out  STEP_COUNT_BITS  index of the maximum-magnitude step
PEAK_PHASE_INC  out  PHASE_INCREMENT_BITS  increment at that step
DONE  out  1  one-CE-cycle pulse when a sweep completes

Behaviour:
- Reset (async assert, sync deassert inside the block):
  - State is IDLE.
  - All outputs are 0, except PHASE_INCREMENT_OUT, which is 0 until the first START.
- In IDLE, PHASE_INCREMENT_OUT holds its last value, so the frontend stays on the last tuned frequency.
- FSM; transitions are evaluated only on CE=1 cycles:
  - IDLE -> LOAD on START.
  - LOAD:
    - PHASE_INCREMENT_OUT <= START_PHASE_INC.
    - Step index <= 0.
    - Settle counter <= SETTLE_CYCLES.
    - Peak magnitude is cleared to 0 and the peak-valid flag is cleared.
    - Next state is SETTLE.
  - SETTLE: decrement the counter each CE cycle; at 0 go to CAPTURE. With SETTLE_CYCLES=0, SETTLE lasts exactly 1 cycle.
  - CAPTURE:
    - Register SIN_MUL_ACC, COS_MUL_ACC and the index into the RES_* outputs; assert RES_VALID.
    - Compute mag = |SIN|+|COS| as unsigned with MUL_ACC_WIDTH+1 bits. |most-negative| = 2^(W-1) is exact and does not saturate.
    - If peak-valid is 0, or mag > peak: update PEAK_INDEX and PEAK_PHASE_INC and set peak-valid. Ties keep the earlier step.
    - Next state is OUTPUT.
  - OUTPUT:
    - Hold RES_* stable while RES_VALID=1 and RES_READY=0.
    - On RES_VALID&RES_READY, deassert RES_VALID.
    - If index = N-1, go to FINISH.
    - Otherwise go to STEP: PHASE_INCREMENT_OUT += STEP_PHASE_INC (modulo 2^PHASE_INCREMENT_BITS wrap), index++, reload the settle counter, then go to SETTLE.
  - FINISH: pulse DONE for 1 CE cycle, then go to IDLE.
- Latency per step is 1 (STEP/LOAD) + SETTLE_CYCLES+1 + 1 (CAPTURE) + handshake wait, counted in CE cycles. With RES_READY tied to 1, a step is SETTLE_CYCLES+4 CE cycles.
- CE=0:
  - No state change, and the counter does not decrement.
  - RES_VALID and data hold. A handshake seen while CE=0 does not complete; the handshake is only sampled on CE=1.
- ABORT has priority over every transition, including START in the same cycle:
  - Next state is IDLE and RES_VALID is dropped.
  - DONE is not pulsed.
  - PEAK_* keep the values from completed captures.
  - PHASE_INCREMENT_OUT holds.
- START while BUSY is ignored; sampled configuration does not change mid-sweep.
- RESET_N assertion mid-sweep: immediate return to reset values.

Decomposition:
- Shared package: the FSM state encoding localparams (IDLE, LOAD, SETTLE, CAPTURE, OUTPUT, STEP, FINISH) and the magnitude width function (MUL_ACC_WIDTH+1).
- One sub-module, sweep_peak_tracker: abs/sum magnitude, compare and the peak registers, with a clear input and a capture strobe.

Test Plan:
1. Basic sweep, result content: START_PHASE_INC=0x100000, STEP=0x1000, N=4, SETTLE=8, RES_READY=1 -> 4 results with indices 0..3; PHASE_INCREMENT_OUT at the 4th capture = 0x103000.
2. Basic sweep, timing: same setup -> DONE pulses exactly once, 48 CE cycles after START (4 steps x 12 CE cycles), then BUSY=0.
3. Peak tracking: drive SIN/COS per step as (5,-3), (-7,2), (4,5), (-9,0) -> mags 8, 9, 9, 9 -> PEAK_INDEX=1 (ties keep earliest). Then (0x80000000,0) at step 0 of a new sweep -> mag 2^31 is selected.
4. Backpressure: RES_READY=0 for 20 cycles at step 1 -> RES_VALID, RES_SIN/COS and RES_INDEX stay constant and PHASE_INCREMENT_OUT does not advance; the sweep resumes on RES_READY=1.
5. Wrap and CE gating: START=0xFFFFFF0, STEP=0x20, N=2 -> step 1 increment = 0x0000010. CE toggling 1/0 doubles the wall-clock duration with identical results.
6. ABORT/START/reset corner cases:
   - ABORT during SETTLE of step 2 -> IDLE next CE cycle, no DONE, RES_VALID=0, PEAK_* from steps 0-1 retained.
   - START+ABORT in the same cycle -> stays IDLE.
   - RESET_N low mid-OUTPUT -> all outputs 0 asynchronously.
